ifetch_unit: RTL and testbench

- Instruction-fetch initiator on the CPU side of the instruction-ROM request/response interface.
- Drives word address plus a one-cycle request strobe to the ROM, then captures the returned instruction on the ROM's output-valid strobe.
- Queues fetched instructions in a small prefetch FIFO for the decode stage.
- Supports branch redirect (flush plus discard of any in-flight response) and a response timeout with retry.

---
 rtl/ifetch_unit.sv | 153 +++++++++++++++
 tb/tb_ifetch_unit.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction-fetch initiator: issues one-at-a-time ROM requests, buffers returned
// instructions in a prefetch FIFO, and handles branch redirect and response timeout.
module ifetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] rom_addr,
  output logic        rom_ready,
  input  logic [15:0] rom_dout,
  input  logic        rom_en_out,
  output logic [15:0] ins,
  output logic        ins_valid,
  input  logic        ins_ack,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        fetch_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = 8;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [15:0]   r_pc, w_pc_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic          r_err, w_err_nxt;
  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push, w_pop, w_full, w_timeout;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_timeout = (r_timer == TMAX);
  assign w_pop     = ins_ack && (r_count != '0) && !redirect;

  // Next-state logic; redirect overrides the normal transitions last.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_timer_nxt = r_timer;
    w_err_nxt   = r_err;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_full) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        w_timer_nxt = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (rom_en_out) begin
          w_push      = 1'b1;
          w_pc_nxt    = r_pc + 16'd1;
          w_state_nxt = S_IDLE;
        end else if (w_timeout) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_REQ;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      S_DRAIN: begin
        if (rom_en_out) begin
          w_state_nxt = S_IDLE;
        end else if (w_timeout) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (redirect) begin
      w_push   = 1'b0;
      w_pc_nxt = redirect_pc;
      case (r_state)
        S_IDLE: w_state_nxt = S_IDLE;
        // The strobe driven this cycle leaves a response in flight.
        S_REQ:  w_state_nxt = S_DRAIN;
        S_WAIT: begin
          if (rom_en_out) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DRAIN;
            w_timer_nxt = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_timer <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_timer <= w_timer_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Prefetch FIFO pointers and occupancy; redirect flushes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (redirect) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= rom_dout;
  end

  assign rom_addr  = r_pc;
  assign rom_ready = (r_state == S_REQ);
  assign ins_valid = (r_count != '0);
  assign ins       = ins_valid ? r_mem[r_rptr] : 16'h0000;
  assign fetch_err = r_err;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: behavioural ROM, FIFO/pc scoreboard monitor, scenario tasks.
module tb_ifetch_unit;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] rom_addr, ins, rom_addr2, ins2;
  logic        rom_ready, ins_valid, fetch_err, rom_ready2, ins_valid2, fetch_err2;
  logic [15:0] rom_dout = 16'h0000;
  logic        rom_en_out = 1'b0;
  logic [15:0] rom_dout2 = 16'h0000;
  logic        rom_en2 = 1'b0;
  logic        ins_ack = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  ifetch_unit #(.DEPTH(DEPTH), .RESET_PC(16'h0000), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_ready(rom_ready),
    .rom_dout(rom_dout), .rom_en_out(rom_en_out), .ins(ins), .ins_valid(ins_valid),
    .ins_ack(ins_ack), .redirect(redirect), .redirect_pc(redirect_pc), .fetch_err(fetch_err)
  );

  ifetch_unit #(.DEPTH(DEPTH), .RESET_PC(16'hFFFF), .TIMEOUT(TIMEOUT)) dut2 (
    .clk(clk), .rst(rst), .rom_addr(rom_addr2), .rom_ready(rom_ready2),
    .rom_dout(rom_dout2), .rom_en_out(rom_en2), .ins(ins2), .ins_valid(ins_valid2),
    .ins_ack(1'b1), .redirect(1'b0), .redirect_pc(16'h0000), .fetch_err(fetch_err2)
  );

  // ROM model: dout = addr ^ A5A5 after rom_lat cycles (0 = never answers).
  int          rom_lat = 1;
  int          rsp_cnt = 0;
  logic [15:0] rsp_addr = 16'h0000;
  always begin
    @(negedge clk);
    rom_en_out = 1'b0;
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        rom_en_out = 1'b1;
        rom_dout   = rsp_addr ^ 16'hA5A5;
      end
    end
    if (rom_ready) begin
      rsp_addr = rom_addr;
      rsp_cnt  = rom_lat;
    end
  end

  logic        pend2 = 1'b0;
  logic [15:0] addr2 = 16'h0000;
  always begin
    @(negedge clk);
    rom_en2   = pend2;
    rom_dout2 = addr2 ^ 16'hA5A5;
    pend2     = rom_ready2;
    addr2     = rom_addr2;
  end

  // Scoreboard: expected FIFO contents and pc, updated with the edge that ends each cycle.
  logic [15:0] sq[$];
  logic [15:0] req_log[$], ack_log[$], req2_log[$], ins2_log[$];
  int          req_cyc[$];
  logic [15:0] exp_pc = 16'h0000;
  logic        outstanding = 1'b0, discard = 1'b0, prev_req = 1'b0;
  logic        exp_valid;
  logic [15:0] exp_ins;
  always begin
    @(negedge clk);
    #2;
    cyc++;
    if (!rst) begin
      sq.delete();
      exp_pc = 16'h0000;
      outstanding = 1'b0;
      discard = 1'b0;
      prev_req = 1'b0;
    end else begin
      if (rom_ready2) req2_log.push_back(rom_addr2);
      if (ins_valid2) ins2_log.push_back(ins2);
      n_chk++;
      if (rom_addr !== exp_pc) begin
        n_fail++;
        $display("FAIL mon_pc: rom_addr=%h expected %h (cycle %0d)", rom_addr, exp_pc, cyc);
      end
      exp_valid = (sq.size() != 0);
      exp_ins   = exp_valid ? sq[0] : 16'h0000;
      n_chk++;
      if (ins_valid !== exp_valid || ins !== exp_ins) begin
        n_fail++;
        $display("FAIL mon_fifo: ins_valid=%b ins=%h expected %b %h (cycle %0d)",
                 ins_valid, ins, exp_valid, exp_ins, cyc);
      end
      if (rom_ready) begin
        n_chk++;
        if (prev_req) begin
          n_fail++;
          $display("FAIL mon_strobe: rom_ready high two consecutive cycles (cycle %0d)", cyc);
        end
        req_log.push_back(rom_addr);
        req_cyc.push_back(cyc);
      end
      prev_req = rom_ready;
      if (ins_ack && ins_valid && !redirect) begin
        ack_log.push_back(ins);
        if (sq.size() != 0) void'(sq.pop_front());
      end
      if (redirect) sq.delete();
      if (rom_en_out && outstanding) begin
        if (!redirect && !discard) begin
          n_chk++;
          if (sq.size() >= DEPTH) begin
            n_fail++;
            $display("FAIL mon_overflow: push with %0d entries, capacity %0d", sq.size(), DEPTH);
          end
          sq.push_back(rom_dout);
          exp_pc = exp_pc + 16'd1;
        end
        outstanding = 1'b0;
        discard = 1'b0;
      end
      if (redirect) begin
        exp_pc = redirect_pc;
        if (outstanding || rom_ready) discard = 1'b1;
      end
      if (rom_ready) outstanding = 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ins_ack = 1'b0;
    redirect = 1'b0;
    redirect_pc = 16'h0000;
    repeat (3) step();
    req_log.delete();
    ack_log.delete();
    req_cyc.delete();
    rst = 1'b1;
  endtask

  task automatic wait_req(input int max_cyc);
    int n = 0;
    step();
    while (!rom_ready && n < max_cyc) begin
      step();
      n++;
    end
    n_chk++;
    if (!rom_ready) begin
      n_fail++;
      $display("FAIL wait_req: no rom_ready within %0d cycles", max_cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) step();
    n_chk++;
    if (rom_ready !== 1'b0 || rom_addr !== 16'h0000 || ins !== 16'h0000 ||
        ins_valid !== 1'b0 || fetch_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b addr=%h ins=%h valid=%b err=%b expected 0 0000 0000 0 0",
               rom_ready, rom_addr, ins, ins_valid, fetch_err);
    end
    n_chk++;
    if (rom_addr2 !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL reset_pc2: rom_addr=%h expected ffff", rom_addr2);
    end
  endtask

  task automatic test_stream();
    logic [15:0] exp_a[3];
    logic [15:0] exp_d[3];
    exp_a[0] = 16'h0000; exp_a[1] = 16'h0001; exp_a[2] = 16'h0002;
    exp_d[0] = 16'hA5A5; exp_d[1] = 16'hA5A4; exp_d[2] = 16'hA5A7;
    rom_lat = 1;
    do_reset();
    ins_ack = 1'b1;
    step();
    n_chk++;
    if (rom_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL first_req: rom_ready=%b expected 1 on 2nd edge after reset", rom_ready);
    end
    repeat (12) step();
    n_chk++;
    if (req_log.size() < 3 || ack_log.size() < 3) begin
      n_fail++;
      $display("FAIL stream_count: %0d requests %0d consumed, expected at least 3 each",
               req_log.size(), ack_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if (req_log[i] !== exp_a[i] || ack_log[i] !== exp_d[i]) begin
          n_fail++;
          $display("FAIL stream_%0d: addr=%h ins=%h expected %h %h",
                   i, req_log[i], ack_log[i], exp_a[i], exp_d[i]);
        end
      end
      n_chk++;
      if (req_cyc[1] - req_cyc[0] != 3 || req_cyc[2] - req_cyc[1] != 3) begin
        n_fail++;
        $display("FAIL stream_rate: request spacing %0d,%0d expected 3,3",
                 req_cyc[1] - req_cyc[0], req_cyc[2] - req_cyc[1]);
      end
    end
  endtask

  task automatic test_backpressure();
    rom_lat = 1;
    do_reset();
    repeat (20) step();
    n_chk++;
    if (req_log.size() != DEPTH || rom_ready !== 1'b0 || ins_valid !== 1'b1 || ins !== 16'hA5A5) begin
      n_fail++;
      $display("FAIL full_stall: reqs=%0d ready=%b valid=%b ins=%h expected %0d 0 1 a5a5",
               req_log.size(), rom_ready, ins_valid, ins, DEPTH);
    end
    req_log.delete();
    ins_ack = 1'b1;
    step();
    ins_ack = 1'b0;
    repeat (10) step();
    n_chk++;
    if (req_log.size() != 1 || req_log[0] !== 16'h0004) begin
      n_fail++;
      $display("FAIL refill: %0d requests first addr=%h expected 1 at 0004",
               req_log.size(), req_log.size() != 0 ? req_log[0] : 16'h0000);
    end
  endtask

  task automatic test_redirect_wait();
    int n = 0;
    rom_lat = 2;
    do_reset();
    wait_req(10);
    step();
    redirect = 1'b1;
    redirect_pc = 16'h0100;
    req_log.delete();
    step();
    redirect = 1'b0;
    while (!ins_valid && n < 20) begin
      step();
      n++;
    end
    n_chk++;
    if (ins_valid !== 1'b1 || ins !== 16'hA4A5) begin
      n_fail++;
      $display("FAIL redir_data: valid=%b ins=%h expected 1 a4a5", ins_valid, ins);
    end
    n_chk++;
    if (req_log.size() != 1 || req_log[0] !== 16'h0100) begin
      n_fail++;
      $display("FAIL redir_addr: %0d requests first addr=%h expected 1 at 0100",
               req_log.size(), req_log.size() != 0 ? req_log[0] : 16'h0000);
    end
  endtask

  task automatic test_redirect_collide();
    int n = 0;
    int t = 0;
    rom_lat = 1;
    do_reset();
    while (n < 3 && t < 30) begin
      step();
      t++;
      if (rom_ready) n++;
    end
    step();
    n_chk++;
    if (ins_valid !== 1'b1 || rom_en_out !== 1'b1) begin
      n_fail++;
      $display("FAIL collide_setup: valid=%b rom_en_out=%b expected 1 1", ins_valid, rom_en_out);
    end
    redirect = 1'b1;
    redirect_pc = 16'h0200;
    ins_ack = 1'b1;
    step();
    redirect = 1'b0;
    ins_ack = 1'b0;
    n_chk++;
    if (ins_valid !== 1'b0 || ins !== 16'h0000 || rom_addr !== 16'h0200 || rom_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL collide_flush: valid=%b ins=%h addr=%h ready=%b expected 0 0000 0200 0",
               ins_valid, ins, rom_addr, rom_ready);
    end
    step();
    n_chk++;
    if (rom_ready !== 1'b1 || rom_addr !== 16'h0200) begin
      n_fail++;
      $display("FAIL collide_idle: ready=%b addr=%h expected 1 0200", rom_ready, rom_addr);
    end
    repeat (4) step();
  endtask

  task automatic test_timeout();
    rom_lat = 0;
    do_reset();
    ins_ack = 1'b1;
    wait_req(10);
    repeat (TIMEOUT) step();
    n_chk++;
    if (fetch_err !== 1'b0 || rom_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_early: err=%b ready=%b in last wait cycle expected 0 0", fetch_err, rom_ready);
    end
    rom_lat = 1;
    step();
    n_chk++;
    if (fetch_err !== 1'b1 || rom_ready !== 1'b1 || rom_addr !== 16'h0000) begin
      n_fail++;
      $display("FAIL tmo_retry: err=%b ready=%b addr=%h expected 1 1 0000", fetch_err, rom_ready, rom_addr);
    end
    repeat (6) step();
    n_chk++;
    if (fetch_err !== 1'b1 || ack_log.size() == 0 || ack_log[0] !== 16'hA5A5) begin
      n_fail++;
      $display("FAIL tmo_recover: err=%b consumed=%0d first=%h expected 1 >=1 a5a5",
               fetch_err, ack_log.size(), ack_log.size() != 0 ? ack_log[0] : 16'h0000);
    end
  endtask

  task automatic test_reset_mid_wrap();
    rom_lat = 3;
    ins_ack = 1'b1;
    step();
    wait_req(10);
    step();
    rst = 1'b0;
    #1;
    n_chk++;
    if (rom_ready !== 1'b0 || rom_addr !== 16'h0000 || ins !== 16'h0000 ||
        ins_valid !== 1'b0 || fetch_err !== 1'b0 || rom_addr2 !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL async_reset: ready=%b addr=%h ins=%h valid=%b err=%b addr2=%h expected 0 0000 0000 0 0 ffff",
               rom_ready, rom_addr, ins, ins_valid, fetch_err, rom_addr2);
    end
    repeat (2) step();
    req_log.delete();
    req2_log.delete();
    ins2_log.delete();
    rst = 1'b1;
    step();
    n_chk++;
    if (rom_ready !== 1'b1 || rom_addr !== 16'h0000 || ins_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_ignored: ready=%b addr=%h valid=%b expected 1 0000 0", rom_ready, rom_addr, ins_valid);
    end
    repeat (10) step();
    n_chk++;
    if (req2_log.size() < 2 || req2_log[0] !== 16'hFFFF || req2_log[1] !== 16'h0000) begin
      n_fail++;
      $display("FAIL wrap_addr: %0d requests first two %h %h expected ffff 0000", req2_log.size(),
               req2_log.size() > 0 ? req2_log[0] : 16'h0000, req2_log.size() > 1 ? req2_log[1] : 16'h0000);
    end
    n_chk++;
    if (ins2_log.size() < 2 || ins2_log[0] !== 16'h5A5A || ins2_log[1] !== 16'hA5A5) begin
      n_fail++;
      $display("FAIL wrap_data: %0d instructions first two %h %h expected 5a5a a5a5", ins2_log.size(),
               ins2_log.size() > 0 ? ins2_log[0] : 16'h0000, ins2_log.size() > 1 ? ins2_log[1] : 16'h0000);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_collide();
    test_timeout();
    test_reset_mid_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
